// File: rtl/mandel_frame_scheduler.sv
// Frame scheduler for a Mandelbrot iteration engine: walks the pixel raster,
// issues one coordinate pair per pixel and streams results through a 2-entry FIFO.
module mandel_frame_scheduler #(
  parameter int BITWIDTH = 11,
  parameter int CTRWIDTH = 7,
  parameter int H_RES    = 160,
  parameter int V_RES    = 120
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [BITWIDTH-1:0] cr_offset,
  input  logic [BITWIDTH-1:0] ci_offset,
  input  logic [1:0]          scaling,
  output logic                eng_run,
  output logic [BITWIDTH-1:0] eng_cr,
  output logic [BITWIDTH-1:0] eng_ci,
  input  logic                eng_done,
  input  logic [CTRWIDTH-1:0] eng_ctr,
  output logic                pix_valid,
  input  logic                pix_ready,
  output logic [CTRWIDTH-1:0] pix_data,
  output logic                pix_last,
  output logic                busy,
  output logic                frame_done
);

  localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam int FW = CTRWIDTH + 1;
  localparam logic [XW-1:0] X_MAX = XW'(H_RES - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(V_RES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t              state_r;
  state_t              state_s;

  logic [XW-1:0]       x_r;
  logic [YW-1:0]       y_r;
  logic [BITWIDTH-1:0] cr_lat_r;
  logic [BITWIDTH-1:0] ci_lat_r;
  logic [1:0]          scl_r;
  logic                eng_run_r;
  logic [BITWIDTH-1:0] eng_cr_r;
  logic [BITWIDTH-1:0] eng_ci_r;
  logic                busy_r;
  logic                frame_done_r;

  logic [FW-1:0]       fifo_mem_r [0:1];
  logic                wr_ptr_r;
  logic                rd_ptr_r;
  logic [1:0]          count_r;

  logic                latch_s;
  logic                issue_s;
  logic                push_s;
  logic                pop_s;
  logic                flush_s;
  logic                done_s;
  logic                last_s;
  logic [BITWIDTH-1:0] cr_nxt_s;
  logic [BITWIDTH-1:0] ci_nxt_s;

  assign last_s   = (x_r == X_MAX) && (y_r == Y_MAX);
  assign cr_nxt_s = cr_lat_r + (BITWIDTH'(x_r) << scl_r);
  assign ci_nxt_s = ci_lat_r + (BITWIDTH'(y_r) << scl_r);
  assign pop_s    = (count_r != 2'd0) && pix_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; abort wins over every other event outside IDLE
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_s = S_ISSUE;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (abort) begin
          state_s = S_IDLE;
        end else if (count_r < 2'd2) begin
          state_s = S_WAIT;
        end else begin
          state_s = S_ISSUE;
        end
      end
      S_WAIT: begin
        if (abort) begin
          state_s = S_IDLE;
        end else if (eng_done) begin
          state_s = last_s ? S_DRAIN : S_ISSUE;
        end else begin
          state_s = S_WAIT;
        end
      end
      S_DRAIN: begin
        if (abort) begin
          state_s = S_IDLE;
        end else if (count_r == 2'd0) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_DRAIN;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // Per-state control strobes
  always_comb begin
    latch_s = 1'b0;
    issue_s = 1'b0;
    push_s  = 1'b0;
    flush_s = 1'b0;
    done_s  = 1'b0;
    case (state_r)
      S_IDLE: begin
        latch_s = start;
      end
      S_ISSUE: begin
        flush_s = abort;
        issue_s = !abort && (count_r < 2'd2);
      end
      S_WAIT: begin
        flush_s = abort;
        push_s  = !abort && eng_done;
      end
      S_DRAIN: begin
        flush_s = abort;
        done_s  = !abort && (count_r == 2'd0);
      end
      default: begin
        flush_s = 1'b1;
      end
    endcase
  end

  // Frame parameters, raster position and registered engine/status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_r          <= {XW{1'b0}};
      y_r          <= {YW{1'b0}};
      cr_lat_r     <= {BITWIDTH{1'b0}};
      ci_lat_r     <= {BITWIDTH{1'b0}};
      scl_r        <= 2'd0;
      eng_run_r    <= 1'b0;
      eng_cr_r     <= {BITWIDTH{1'b0}};
      eng_ci_r     <= {BITWIDTH{1'b0}};
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      eng_run_r    <= issue_s;
      frame_done_r <= done_s;
      if (latch_s) begin
        cr_lat_r <= cr_offset;
        ci_lat_r <= ci_offset;
        scl_r    <= scaling;
        x_r      <= {XW{1'b0}};
        y_r      <= {YW{1'b0}};
        busy_r   <= 1'b1;
      end else if (flush_s || done_s) begin
        busy_r <= 1'b0;
      end
      // Coordinates only move at issue, so they hold until the matching eng_done
      if (issue_s) begin
        eng_cr_r <= cr_nxt_s;
        eng_ci_r <= ci_nxt_s;
      end
      if (push_s && !last_s) begin
        if (x_r == X_MAX) begin
          x_r <= {XW{1'b0}};
          y_r <= y_r + YW'(1);
        end else begin
          x_r <= x_r + XW'(1);
        end
      end
    end
  end

  // Two-entry result FIFO; issue only happens with a free slot, so push never overflows
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_mem_r[0] <= {FW{1'b0}};
      fifo_mem_r[1] <= {FW{1'b0}};
      wr_ptr_r      <= 1'b0;
      rd_ptr_r      <= 1'b0;
      count_r       <= 2'd0;
    end else if (flush_s) begin
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= {last_s, eng_ctr};
        wr_ptr_r             <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      if (push_s && !pop_s) begin
        count_r <= count_r + 2'd1;
      end else if (!push_s && pop_s) begin
        count_r <= count_r - 2'd1;
      end
    end
  end

  assign eng_run    = eng_run_r;
  assign eng_cr     = eng_cr_r;
  assign eng_ci     = eng_ci_r;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;
  assign pix_valid  = (count_r != 2'd0);
  assign pix_data   = fifo_mem_r[rd_ptr_r][CTRWIDTH-1:0];
  assign pix_last   = fifo_mem_r[rd_ptr_r][CTRWIDTH];

endmodule

// File: tb/tb_mandel_frame_scheduler.sv
// Directed bench for mandel_frame_scheduler on a 4x2 raster with a 3-cycle engine model.
module tb_mandel_frame_scheduler;

  localparam int BW = 11;
  localparam int CW = 7;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic [BW-1:0] cr_offset;
  logic [BW-1:0] ci_offset;
  logic [1:0]    scaling;
  logic          eng_run;
  logic [BW-1:0] eng_cr;
  logic [BW-1:0] eng_ci;
  logic          eng_done = 1'b0;
  logic [CW-1:0] eng_ctr  = 7'd0;
  logic          pix_valid;
  logic          pix_ready;
  logic [CW-1:0] pix_data;
  logic          pix_last;
  logic          busy;
  logic          frame_done;

  int checks   = 0;
  int failures = 0;

  int eng_seq  = 0;
  int ctr_base = 0;

  int run_cnt = 0;
  int pix_cnt = 0;
  int fd_cnt  = 0;
  int dup_cnt = 0;
  logic run_prev = 1'b0;
  logic fd_busy  = 1'b1;
  logic [BW-1:0] cr_log [0:255];
  logic [BW-1:0] ci_log [0:255];
  logic [CW-1:0] pd_log [0:255];
  logic          pl_log [0:255];

  int run_base;
  int pix_base;
  int fd_base;
  int rb;

  mandel_frame_scheduler #(
    .BITWIDTH(BW), .CTRWIDTH(CW), .H_RES(4), .V_RES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cr_offset(cr_offset), .ci_offset(ci_offset), .scaling(scaling),
    .eng_run(eng_run), .eng_cr(eng_cr), .eng_ci(eng_ci),
    .eng_done(eng_done), .eng_ctr(eng_ctr),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .pix_last(pix_last), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Engine model: answers each eng_run three cycles later with the raster index
  always begin
    @(negedge clk);
    if (eng_run === 1'b1) begin
      eng_ctr = 7'(eng_seq - ctr_base);
      eng_seq = eng_seq + 1;
      @(posedge clk);
      @(posedge clk);
      #1 eng_done = 1'b1;
      @(posedge clk);
      #1 eng_done = 1'b0;
    end
  end

  // Output monitor sampled mid-cycle
  always begin
    @(negedge clk);
    if (eng_run === 1'b1) begin
      cr_log[run_cnt & 255] = eng_cr;
      ci_log[run_cnt & 255] = eng_ci;
      run_cnt = run_cnt + 1;
      if (run_prev === 1'b1) dup_cnt = dup_cnt + 1;
    end
    run_prev = eng_run;
    if (pix_valid === 1'b1 && pix_ready === 1'b1) begin
      pd_log[pix_cnt & 255] = pix_data;
      pl_log[pix_cnt & 255] = pix_last;
      pix_cnt = pix_cnt + 1;
    end
    if (frame_done === 1'b1) begin
      fd_cnt  = fd_cnt + 1;
      fd_busy = busy;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      failures = failures + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_frame(input logic [BW-1:0] cr, input logic [BW-1:0] ci, input logic [1:0] scl);
    cr_offset = cr;
    ci_offset = ci;
    scaling   = scl;
    ctr_base  = eng_seq;
    run_base  = run_cnt;
    pix_base  = pix_cnt;
    fd_base   = fd_cnt;
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_fd(input string tag, input int limit);
    int n;
    n = 0;
    while ((fd_cnt - fd_base) < 1 && n < limit) begin
      @(negedge clk);
      n = n + 1;
    end
    chk(tag, 32'((fd_cnt - fd_base) >= 1), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_runs(input string tag, input int num, input int limit);
    int n;
    n = 0;
    while ((run_cnt - run_base) < num && n < limit) begin
      @(negedge clk);
      n = n + 1;
    end
    chk(tag, 32'(run_cnt - run_base), 32'(num));
  endtask

  task automatic check_pixels(input string tag);
    chk({tag, "_npix"}, 32'(pix_cnt - pix_base), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s_data%0d", tag, i), 32'(pd_log[(pix_base + i) & 255]), 32'(i));
      chk($sformatf("%s_last%0d", tag, i), 32'(pl_log[(pix_base + i) & 255]), 32'(i == 7));
    end
  endtask

  task automatic check_coords(input string tag, input logic [BW-1:0] cr0, input logic [BW-1:0] ci0, input int scl);
    logic [BW-1:0] ecr;
    logic [BW-1:0] eci;
    chk({tag, "_nrun"}, 32'(run_cnt - run_base), 32'd8);
    for (int i = 0; i < 8; i++) begin
      ecr = cr0 + BW'((i % 4) << scl);
      eci = ci0 + BW'((i / 4) << scl);
      chk($sformatf("%s_cr%0d", tag, i), 32'(cr_log[(run_base + i) & 255]), 32'(ecr));
      chk($sformatf("%s_ci%0d", tag, i), 32'(ci_log[(run_base + i) & 255]), 32'(eci));
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    cr_offset = 11'h000;
    ci_offset = 11'h000;
    scaling   = 2'd0;
    pix_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_eng_run", 32'(eng_run), 32'd0);
    chk("rst_eng_cr", 32'(eng_cr), 32'd0);
    chk("rst_eng_ci", 32'(eng_ci), 32'd0);
    chk("rst_pix_valid", 32'(pix_valid), 32'd0);
    chk("rst_pix_last", 32'(pix_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full frame; offsets disturbed after the latch must not matter
    pix_ready = 1'b1;
    start_frame(11'h010, 11'h020, 2'd1);
    chk("t1_busy_after_start", 32'(busy), 32'd1);
    cr_offset = 11'h3AA;
    ci_offset = 11'h155;
    scaling   = 2'd3;
    wait_fd("t1_fd_timeout", 300);
    check_coords("t1", 11'h010, 11'h020, 1);
    check_pixels("t1");
    chk("t1_fd_count", 32'(fd_cnt - fd_base), 32'd1);
    chk("t1_busy_at_fd", 32'(fd_busy), 32'd0);
    chk("t1_busy_end", 32'(busy), 32'd0);
    chk("t1_pix_valid_end", 32'(pix_valid), 32'd0);
    @(posedge clk);
    #1;

    // Backpressure: FIFO fills after two issues, then stalls
    pix_ready = 1'b0;
    start_frame(11'h010, 11'h020, 2'd1);
    repeat (40) @(posedge clk);
    #1;
    chk("t2_runs_held", 32'(run_cnt - run_base), 32'd2);
    chk("t2_pix_valid", 32'(pix_valid), 32'd1);
    chk("t2_pix_data", 32'(pix_data), 32'd0);
    chk("t2_pix_last", 32'(pix_last), 32'd0);
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1 start = 1'b0;
    chk("t2_start_ignored", 32'(run_cnt - run_base), 32'd2);
    pix_ready = 1'b1;
    wait_fd("t2_fd_timeout", 300);
    check_pixels("t2");
    check_coords("t2", 11'h010, 11'h020, 1);
    chk("t2_fd_count", 32'(fd_cnt - fd_base), 32'd1);
    @(posedge clk);
    #1;

    // Coordinate wrap, plus start held during DRAIN
    pix_ready = 1'b1;
    start_frame(11'h7FE, 11'h000, 2'd0);
    wait_runs("t3_runs_timeout", 8, 300);
    @(posedge clk);
    #1 pix_ready = 1'b0;
    repeat (8) @(posedge clk);
    #1 start = 1'b1;
    repeat (4) @(posedge clk);
    #1 start = 1'b0;
    chk("t3_no_extra_run", 32'(run_cnt - run_base), 32'd8);
    chk("t3_busy_drain", 32'(busy), 32'd1);
    chk("t3_pix_valid_drain", 32'(pix_valid), 32'd1);
    chk("t3_pix_data_drain", 32'(pix_data), 32'd7);
    chk("t3_pix_last_drain", 32'(pix_last), 32'd1);
    pix_ready = 1'b1;
    wait_fd("t3_fd_timeout", 100);
    check_coords("t3", 11'h7FE, 11'h000, 0);
    check_pixels("t3");
    chk("t3_fd_count", 32'(fd_cnt - fd_base), 32'd1);
    @(posedge clk);
    #1;

    // Abort in WAIT with one FIFO entry; late eng_done must be ignored
    pix_ready = 1'b0;
    start_frame(11'h000, 11'h000, 2'd0);
    wait_runs("t4_runs_timeout", 2, 100);
    @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    chk("t4_pix_valid_abort", 32'(pix_valid), 32'd0);
    chk("t4_busy_abort", 32'(busy), 32'd0);
    repeat (6) @(negedge clk);
    chk("t4_no_fd", 32'(fd_cnt - fd_base), 32'd0);
    chk("t4_no_more_runs", 32'(run_cnt - run_base), 32'd2);
    chk("t4_pix_valid_late", 32'(pix_valid), 32'd0);
    chk("t4_busy_late", 32'(busy), 32'd0);
    @(posedge clk);
    #1 pix_ready = 1'b1;
    start_frame(11'h100, 11'h050, 2'd2);
    wait_fd("t4_fd_timeout", 300);
    check_coords("t4", 11'h100, 11'h050, 2);
    check_pixels("t4");
    chk("t4_fd_count", 32'(fd_cnt - fd_base), 32'd1);
    @(posedge clk);
    #1;

    // Asynchronous reset between edges mid-frame
    start_frame(11'h010, 11'h020, 2'd1);
    wait_runs("t5_runs_timeout", 3, 100);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_eng_run", 32'(eng_run), 32'd0);
    chk("t5_eng_cr", 32'(eng_cr), 32'd0);
    chk("t5_eng_ci", 32'(eng_ci), 32'd0);
    chk("t5_pix_valid", 32'(pix_valid), 32'd0);
    chk("t5_pix_last", 32'(pix_last), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_frame_done", 32'(frame_done), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    rb = run_cnt;
    repeat (8) @(negedge clk);
    chk("t5_no_run_after", 32'(run_cnt - rb), 32'd0);
    chk("t5_idle_busy", 32'(busy), 32'd0);
    chk("t5_idle_pix_valid", 32'(pix_valid), 32'd0);
    chk("eng_run_single_cycle", 32'(dup_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mandel_frame_scheduler.md
MANDEL_FRAME_SCHEDULER -- requirements
Module: mandel_frame_scheduler

Interface
REQ-001 SHALL have parameter BITWIDTH, default 11, coordinate width of the engine.
REQ-002 SHALL have parameter CTRWIDTH, default 7, iteration-count width of the engine.
REQ-003 SHALL have parameter H_RES, default 160, pixels per row (>=2).
REQ-004 SHALL have parameter V_RES, default 120, rows per frame (>=2).
REQ-005 SHALL have ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  begin frame; sampled only in IDLE.
- abort  in  1  cancel frame.
- cr_offset  in  BITWIDTH  real start coordinate.
- ci_offset  in  BITWIDTH  imaginary start coordinate.
- scaling  in  2  step = 1 << scaling.
- eng_run  out  1  one-cycle engine start pulse.
- eng_cr  out  BITWIDTH  real coordinate to engine.
- eng_ci  out  BITWIDTH  imaginary coordinate to engine.
- eng_done  in  1  one-cycle pulse, eng_ctr valid.
- eng_ctr  in  CTRWIDTH  engine iteration count.
- pix_valid  out  1  pixel available to framebuffer writer.
- pix_ready  in  1  writer accepts pixel.
- pix_data  out  CTRWIDTH  pixel iteration count.
- pix_last  out  1  marks last pixel of frame.
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse, frame fully delivered.

Function
REQ-006 SHALL implement FSM states IDLE, ISSUE, WAIT, DRAIN.
REQ-007 In IDLE with start=1: SHALL latch cr_offset, ci_offset, scaling, clear x and y, and enter ISSUE; busy=1 from the next cycle.
REQ-008 Changes to cr_offset, ci_offset and scaling after the latch SHALL NOT affect the running frame.
REQ-009 start SHALL be ignored outside IDLE.
REQ-010 In ISSUE with FIFO count<2: SHALL drive a registered eng_run pulse of exactly one cycle and enter WAIT. With count=2 it SHALL stay in ISSUE.
REQ-011 eng_cr SHALL equal (cr_lat + (x << scaling)) mod 2^BITWIDTH.
REQ-012 eng_ci SHALL equal (ci_lat + (y << scaling)) mod 2^BITWIDTH.
REQ-013 eng_cr and eng_ci SHALL be stable from the eng_run cycle until eng_done.
REQ-014 In WAIT on eng_done: SHALL push {last, eng_ctr} into the FIFO, where last = (x==H_RES-1 && y==V_RES-1).
REQ-015 After that push, if last: SHALL enter DRAIN. Otherwise SHALL advance and return to ISSUE: x+1, or x=0 and y+1 when x==H_RES-1.
REQ-016 eng_done outside WAIT SHALL be ignored.
REQ-017 SHALL contain a 2-entry FIFO of width CTRWIDTH+1. pix_valid = (count!=0). pix_data and pix_last come from the head entry.
REQ-018 A pop SHALL occur when pix_valid && pix_ready. A simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-019 The head entry SHALL hold stable while pix_valid=1 and pix_ready=0.
REQ-020 In DRAIN, when count reaches 0: SHALL pulse frame_done for one cycle and enter IDLE; busy=0 in the same cycle as frame_done.
REQ-021 abort=1 in any non-IDLE state: SHALL enter IDLE next cycle, flush the FIFO (pix_valid=0), clear busy, and not pulse frame_done.
REQ-022 abort=1 in IDLE SHALL have no effect. abort SHALL take priority over start, eng_done and a DRAIN completion in the same cycle.
REQ-023 Exactly H_RES*V_RES pixels SHALL be delivered per completed frame, in raster order (x fastest). pix_last SHALL be 1 only on the final pixel.

Reset
REQ-024 rst_n=0 SHALL asynchronously force: state=IDLE; x=y=0; FIFO count=0; eng_run=0; pix_valid=0; pix_last=0; busy=0; frame_done=0; eng_cr=0; eng_ci=0.
REQ-025 Reset deasserted mid-frame SHALL restart from IDLE, with no pending eng_run or pixel.

Verification
REQ-026 Full frame (H_RES=4, V_RES=2, cr_offset=0x010, ci_offset=0x020, scaling=1; engine model replies eng_done 3 cycles after eng_run with eng_ctr=x+4y; pix_ready=1) -> eight eng_run pulses; eng_cr sequence 0x010,0x012,0x014,0x016 twice; eng_ci 0x020 then 0x022; pix_data 0..7; pix_last only on 7; single frame_done; busy=0.
REQ-027 Backpressure (pix_ready=0 throughout) -> exactly 2 eng_run pulses, then the block holds in ISSUE; pix_data stays 0. Raising pix_ready then completes the frame in order with no loss or duplication.
REQ-028 Wrap (cr_offset=0x7FE, scaling=0, H_RES=4) -> eng_cr sequence 0x7FE, 0x7FF, 0x000, 0x001.
REQ-029 abort asserted in WAIT with one FIFO entry -> next cycle IDLE, pix_valid=0, busy=0, no frame_done; a late eng_done is ignored; a new start runs a full frame from x=y=0.
REQ-030 rst_n pulled low mid-frame, asynchronously between edges -> all outputs immediately at their REQ-024 values; start ignored while busy, and start during DRAIN produces no extra eng_run.
